cmp_arbiter: RTL and testbench



---
 rtl/cmp_arb_pkg.sv | 26 ++
 rtl/cmp_arbiter_rr_arb2.sv | 34 +++
 rtl/cmp_arbiter.sv | 135 +++++++++++++
 tb/tb_cmp_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_arb_pkg.sv
// Shared types and constants for the compare-unit arbiter: FSM states,
// compare function codes and the result codes returned by the compare unit.
package cmp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [1:0] FUN_NOP = 2'b00;
    localparam logic [1:0] FUN_EQ  = 2'b01;
    localparam logic [1:0] FUN_GT  = 2'b10;
    localparam logic [1:0] FUN_LT  = 2'b11;

    localparam int RES_FALSE = 0;
    localparam int RES_EQ    = 1;
    localparam int RES_GT    = 2;
    localparam int RES_LT    = 3;

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cmp_arbiter_rr_arb2.sv
// Two-way round-robin winner select; the pointer records the last served
// requester and the other one wins a tie.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       done_i,
    input  logic       done_idx_i,
    output logic       win_valid_o,
    output logic       win_idx_o
);

    logic ptr_q;

    always_comb begin
        win_valid_o = |req_i;
        win_idx_o   = 1'b0;
        case (req_i)
            2'b10:   win_idx_o = 1'b1;
            2'b11:   win_idx_o = ~ptr_q;
            default: win_idx_o = 1'b0;
        endcase
    end

    // Pointer starts at 1 so requester 0 takes the first tie after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b1;
        end else if (done_i) begin
            ptr_q <= done_idx_i;
        end
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Shares one compare unit between two requesters: arbitrate, issue, wait for
// the flag, return the result. Optional watchdog abort under CMP_ARB_WDOG_EN.
module cmp_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int RES_W       = 16,
    parameter int WDOG_CYCLES = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        REQ,
    input  logic [DATA_W-1:0] REQ0_A,
    input  logic [DATA_W-1:0] REQ0_B,
    input  logic [1:0]        REQ0_FUN,
    input  logic [DATA_W-1:0] REQ1_A,
    input  logic [DATA_W-1:0] REQ1_B,
    input  logic [1:0]        REQ1_FUN,
    output logic [1:0]        GNT,
    output logic [1:0]        RSP_VALID,
    output logic [RES_W-1:0]  RSP_DATA,
    output logic              RSP_ERR,
    output logic [DATA_W-1:0] CMP_A,
    output logic [DATA_W-1:0] CMP_B,
    output logic [1:0]        CMP_FUN,
    output logic              CMP_Enable,
    input  logic [RES_W-1:0]  CMP_OUT,
    input  logic              CMP_Flag
);

    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    state_e            state_q;
    logic [1:0]        gnt_q;
    logic [1:0]        rsp_valid_q;
    logic [RES_W-1:0]  rsp_data_q;
    logic [DATA_W-1:0] cmp_a_q;
    logic [DATA_W-1:0] cmp_b_q;
    logic [1:0]        cmp_fun_q;
    logic              cmp_en_q;
    logic              win_valid;
    logic              win_idx;

    rr_arb2 u_rr (
        .clk_i      (CLK),
        .rst_i      (RST),
        .req_i      (REQ),
        .done_i     (state_q == RESP),
        .done_idx_i (gnt_q[1]),
        .win_valid_o(win_valid),
        .win_idx_o  (win_idx)
    );

`ifdef CMP_ARB_WDOG_EN
    logic [WDOG_W-1:0] wdog_q;
    logic              rsp_err_q;
    assign RSP_ERR = rsp_err_q;
`else
    logic [WDOG_W-1:0] unused_wdog_limit;
    assign unused_wdog_limit = WDOG_W'(WDOG_CYCLES);
    assign RSP_ERR = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            gnt_q       <= 2'b00;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
            cmp_a_q     <= '0;
            cmp_b_q     <= '0;
            cmp_fun_q   <= FUN_NOP;
            cmp_en_q    <= 1'b0;
`ifdef CMP_ARB_WDOG_EN
            wdog_q      <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            cmp_en_q    <= 1'b0;
            rsp_valid_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        cmp_a_q   <= win_idx ? REQ1_A   : REQ0_A;
                        cmp_b_q   <= win_idx ? REQ1_B   : REQ0_B;
                        cmp_fun_q <= win_idx ? REQ1_FUN : REQ0_FUN;
                        gnt_q     <= idx_to_onehot(win_idx);
                        cmp_en_q  <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    // The response pulse is registered here so it lines up with RESP.
                    if (CMP_Flag) begin
                        rsp_data_q  <= CMP_OUT;
                        rsp_valid_q <= gnt_q;
                        state_q     <= RESP;
`ifdef CMP_ARB_WDOG_EN
                        wdog_q      <= '0;
                        rsp_err_q   <= 1'b0;
                    end else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
                        rsp_data_q  <= '0;
                        rsp_valid_q <= gnt_q;
                        rsp_err_q   <= 1'b1;
                        wdog_q      <= '0;
                        state_q     <= RESP;
                    end else begin
                        wdog_q      <= wdog_q + WDOG_W'(1);
`endif
                    end
                end
                RESP: begin
                    gnt_q   <= 2'b00;
                    state_q <= IDLE;
`ifdef CMP_ARB_WDOG_EN
                    rsp_err_q <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign GNT        = gnt_q;
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_DATA   = rsp_data_q;
    assign CMP_A      = cmp_a_q;
    assign CMP_B      = cmp_b_q;
    assign CMP_FUN    = cmp_fun_q;
    assign CMP_Enable = cmp_en_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: directed and random ops against a
// behavioural model, with a stub compare unit that can withhold its flag.
module tb_cmp_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [7:0]  r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic [1:0]  r0_f = '0, r1_f = '0;
    logic [1:0]  gnt, rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [7:0]  cmp_a, cmp_b;
    logic [1:0]  cmp_fun;
    logic        cmp_en;
    logic [15:0] cmp_out, model_out = '0, force_out = '0;
    logic        cmp_flag, model_flag = 1'b0, force_flag = 1'b0, withhold = 1'b0;

    int checks = 0;
    int errors = 0;
    bit last_win = 1'b1;
    logic [15:0] last_data = '0;

    always #5 clk = ~clk;

    cmp_arbiter #(.DATA_W(8), .RES_W(16), .WDOG_CYCLES(8)) dut (
        .CLK(clk), .RST(rst), .REQ(req),
        .REQ0_A(r0_a), .REQ0_B(r0_b), .REQ0_FUN(r0_f),
        .REQ1_A(r1_a), .REQ1_B(r1_b), .REQ1_FUN(r1_f),
        .GNT(gnt), .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err),
        .CMP_A(cmp_a), .CMP_B(cmp_b), .CMP_FUN(cmp_fun), .CMP_Enable(cmp_en),
        .CMP_OUT(cmp_out), .CMP_Flag(cmp_flag)
    );

    function automatic logic [15:0] ref_cmp(input logic [1:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            2'b01:   return (a == b) ? 16'd1 : 16'd0;
            2'b10:   return (a >  b) ? 16'd2 : 16'd0;
            2'b11:   return (a <  b) ? 16'd3 : 16'd0;
            default: return 16'd0;
        endcase
    endfunction

    // Stub compare unit: answers one cycle after seeing the enable.
    always @(posedge clk) begin
        if (rst) begin
            model_flag <= 1'b0;
            model_out  <= '0;
        end else begin
            model_flag <= cmp_en & ~withhold;
            if (cmp_en) model_out <= ref_cmp(cmp_fun, cmp_a, cmp_b);
        end
    end
    assign cmp_flag = model_flag | force_flag;
    assign cmp_out  = force_flag ? force_out : model_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full operation: drive the requests, then check every cycle of it.
    task automatic run_op(input logic [1:0] rq,
                          input logic [7:0] a0, input logic [7:0] b0, input logic [1:0] f0,
                          input logic [7:0] a1, input logic [7:0] b1, input logic [1:0] f1,
                          input bit drop0);
        bit w;
        logic [1:0] oh;
        logic [7:0] ea, eb;
        logic [1:0] ef;
        logic [15:0] er;
        req = rq; r0_a = a0; r0_b = b0; r0_f = f0; r1_a = a1; r1_b = b1; r1_f = f1;
        w  = (rq == 2'b11) ? ~last_win : (rq == 2'b10);
        oh = w ? 2'b10 : 2'b01;
        ea = w ? a1 : a0; eb = w ? b1 : b0; ef = w ? f1 : f0;
        er = ref_cmp(ef, ea, eb);
        tick();
        check("issue_gnt", gnt, oh);
        check("issue_en", cmp_en, 1);
        check("issue_a", cmp_a, ea);
        check("issue_b", cmp_b, eb);
        check("issue_fun", cmp_fun, ef);
        check("issue_novalid", rsp_valid, 0);
        tick();
        check("wait_en_low", cmp_en, 0);
        check("wait_gnt", gnt, oh);
        if (drop0) req[0] = 1'b0;
        tick();
        check("resp_valid", rsp_valid, oh);
        check("resp_data", rsp_data, er);
        check("resp_err", rsp_err, 0);
        check("resp_gnt", gnt, oh);
        tick();
        check("post_valid", rsp_valid, 0);
        check("post_gnt", gnt, 0);
        check("post_data_hold", rsp_data, er);
        check("post_a_hold", cmp_a, ea);
        last_win  = w;
        last_data = er;
        $display("op req=%b win=%0d fun=%b a=%0h b=%0h res=%0h", rq, w, ef, ea, eb, er);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held two cycles
        rst = 1'b1;
        tick(); tick();
        check("rst_gnt", gnt, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_data", rsp_data, 0);
        check("rst_err", rsp_err, 0);
        check("rst_en", cmp_en, 0);
        check("rst_cmp", {cmp_a, cmp_b, cmp_fun}, 0);
        rst = 1'b0;
        $display("reset checked");

        // First tie goes to requester 0
        run_op(2'b11, 8'h35, 8'h35, 2'b01, 8'h01, 8'h02, 2'b11, 0);
        req = 2'b00; tick();
        check("idle_valid", rsp_valid, 0);

        // Single op
        run_op(2'b01, 8'h35, 8'h35, 2'b01, 8'h00, 8'h00, 2'b00, 0);
        req = 2'b00; tick();

        // Contention with REQ held: alternate, 4 cycles per op
        for (int i = 0; i < 4; i++)
            run_op(2'b11, 8'h80, 8'h10, 2'b10, 8'h05, 8'h06, 2'b11, 0);

        // NOP and false compare
        run_op(2'b01, 8'h01, 8'h02, 2'b00, 8'h00, 8'h00, 2'b00, 0);
        run_op(2'b01, 8'h01, 8'h02, 2'b10, 8'h00, 8'h00, 2'b00, 0);
        req = 2'b00; tick();
        check("idle_data_hold", rsp_data, last_data);

        // Requester 0 drops REQ mid-op and still gets its pulse
        run_op(2'b01, 8'h07, 8'h09, 2'b11, 8'h00, 8'h00, 2'b00, 1);
        req = 2'b00; tick();

        // Reset asserted in WAIT aborts the op
        req = 2'b10; r1_a = 8'h44; r1_b = 8'h44; r1_f = 2'b01;
        tick(); tick();
        rst = 1'b1; req = 2'b00;
        tick();
        check("midrst_gnt", gnt, 0);
        check("midrst_valid", rsp_valid, 0);
        check("midrst_en", cmp_en, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_noresp", rsp_valid, 0);
        end
        last_win = 1'b1;
        $display("mid-op reset checked");

        // Compare unit withholds its flag
        withhold = 1'b1;
        req = 2'b01; r0_a = 8'h10; r0_b = 8'h20; r0_f = 2'b11;
        tick();
        check("wd_issue_en", cmp_en, 1);
`ifdef CMP_ARB_WDOG_EN
        for (int i = 0; i < 8; i++) begin
            tick();
            check("wd_no_valid", rsp_valid, 0);
        end
        tick();
        check("wd_valid", rsp_valid, 2'b01);
        check("wd_err", rsp_err, 1);
        check("wd_data", rsp_data, 0);
        withhold = 1'b0; req = 2'b00;
        tick();
        check("wd_post_valid", rsp_valid, 0);
        check("wd_post_gnt", gnt, 0);
        $display("watchdog abort checked");
`else
        for (int i = 0; i < 12; i++) begin
            tick();
            check("hang_no_valid", rsp_valid, 0);
            check("hang_gnt", gnt, 2'b01);
        end
        force_out = 16'h00a5; force_flag = 1'b1;
        tick();
        force_flag = 1'b0; withhold = 1'b0; req = 2'b00;
        check("late_valid", rsp_valid, 2'b01);
        check("late_data", rsp_data, 16'h00a5);
        check("late_err", rsp_err, 0);
        tick();
        check("late_post_valid", rsp_valid, 0);
        $display("late flag checked");
`endif
        last_win = 1'b0;
        run_op(2'b01, 8'h33, 8'h33, 2'b01, 8'h00, 8'h00, 2'b00, 0);

        // Randomized ops
        for (int i = 0; i < 24; i++) begin
            run_op(2'($urandom_range(1, 3)),
                   8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 0);
            if ($urandom_range(0, 1) == 1) begin
                req = 2'b00; tick();
                check("rand_idle_valid", rsp_valid, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
